alu_seq: RTL and testbench

//   Clocked, parametrised successor to the combinational datapath ALU of the
//   CSE141L 9-bit-ISA core. It sits between the register file read ports and
//   the write-back mux.
//   - Registers its result and Zero/Negative/Carry flags.
//   - Holds a persistent, seedable LFSR (state + taps) for the LFSR ops.
//   - Executes shifts iteratively, one bit per cycle.
//   - Control sequences it through a Start/Busy/Done handshake.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered result/flags, a seedable LFSR and
// iterative one-bit-per-cycle shifts, driven by a Start/Busy/Done handshake.
module alu_seq #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_LSL   = 4'd4;
    localparam logic [3:0] OP_LSR   = 4'd5;
    localparam logic [3:0] OP_CMP   = 4'd6;
    localparam logic [3:0] OP_PASS  = 4'd7;
    localparam logic [3:0] OP_PAR   = 4'd8;
    localparam logic [3:0] OP_LSEED = 4'd9;
    localparam logic [3:0] OP_LSTEP = 4'd10;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] r_sh;     // shift operand being worked on
    logic [CW-1:0]    r_cnt;    // shift steps still to do
    logic             r_dir;    // 1 = logical right, 0 = left

    logic [CW-1:0]    w_n;
    logic             w_is_shift;
    logic             w_fb;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_wr;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [WIDTH-1:0] w_taps_nxt;
    logic [WIDTH-1:0] w_sh_nxt;
    logic             w_sh_bit;

    // Shift amount saturates at WIDTH; anything larger shifts everything out.
    assign w_n        = (InputB >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(InputB);
    assign w_is_shift = ((OP == OP_LSL) || (OP == OP_LSR)) && (w_n != '0);
    assign w_fb       = ^(r_lfsr & r_taps);
    assign w_sh_nxt   = r_dir ? (r_sh >> 1) : (r_sh << 1);
    assign w_sh_bit   = r_dir ? r_sh[0] : r_sh[WIDTH-1];

    // Single-cycle result, carry and LFSR update for every non-iterative op.
    always_comb begin
        w_res      = '0;
        w_c        = 1'b0;
        w_wr       = 1'b1;
        w_lfsr_nxt = r_lfsr;
        w_taps_nxt = r_taps;
        case (OP)
            OP_ADD:  {w_c, w_res} = {1'b0, InputA} + {1'b0, InputB};
            OP_SUB: begin
                w_res = InputA - InputB;
                w_c   = (InputA >= InputB);
            end
            OP_XOR:  w_res = InputA ^ InputB;
            OP_AND:  w_res = InputA & InputB;
            // Only reached with a zero shift amount: operand passes through.
            OP_LSL, OP_LSR: w_res = InputA;
            OP_CMP: begin
                w_res = InputA - InputB;
                w_c   = (InputA >= InputB);
                w_wr  = 1'b0;
            end
            OP_PASS: w_res = InputB;
            OP_PAR:  w_res = {^InputB[WIDTH-2:0], InputB[WIDTH-2:0]};
            OP_LSEED: begin
                w_lfsr_nxt = (InputA == '0) ? LFSR_SEED : InputA;
                w_taps_nxt = (InputB == '0) ? LFSR_TAPS : InputB;
                w_res      = InputA;
            end
            OP_LSTEP: begin
                // A stuck-at-zero register recovers by reloading the seed.
                if (r_lfsr == '0) begin
                    w_lfsr_nxt = LFSR_SEED;
                    w_res      = LFSR_SEED;
                end else begin
                    w_lfsr_nxt = {r_lfsr[WIDTH-2:0], w_fb};
                    w_res      = w_lfsr_nxt;
                    w_c        = r_lfsr[WIDTH-1];
                end
            end
            default: w_res = '0;
        endcase
    end

    // Control FSM plus all architectural state; outputs are registered here.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lfsr  <= LFSR_SEED;
            r_taps  <= LFSR_TAPS;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (w_is_shift) begin
                            r_sh    <= InputA;
                            r_cnt   <= w_n;
                            r_dir   <= (OP == OP_LSR);
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end else begin
                            if (w_wr) r_out <= w_res;
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[WIDTH-1];
                            r_carry <= w_c;
                            r_done  <= 1'b1;
                            r_lfsr  <= w_lfsr_nxt;
                            r_taps  <= w_taps_nxt;
                        end
                    end
                end
                S_SHIFT: begin
                    // Start is ignored here; operands were latched on entry.
                    r_sh  <= w_sh_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out   <= w_sh_nxt;
                        r_zero  <= (w_sh_nxt == '0);
                        r_neg   <= w_sh_nxt[WIDTH-1];
                        r_carry <= w_sh_bit;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Out      = r_out;
    assign Zero     = r_zero;
    assign Negative = r_neg;
    assign Carry    = r_carry;
    assign Busy     = r_busy;
    assign Done     = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, handshake corner sequences and a
// randomized run against a behavioural model of alu_seq (WIDTH=8).
module tb_alu_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] OP;
    logic [7:0] InputA, InputB;
    logic [7:0] Out;
    logic       Zero, Negative, Carry, Busy, Done;

    alu_seq dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .OP(OP),
        .InputA(InputA), .InputB(InputB), .Out(Out), .Zero(Zero),
        .Negative(Negative), .Carry(Carry), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int    n_chk  = 0;
    int    n_fail = 0;
    string tag    = "";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    // Behavioural model state: visible result and LFSR.
    logic [7:0] m_out, m_s, m_t;

    task automatic model_reset();
        m_out = 8'h00; m_s = 8'h01; m_t = 8'hB8;
    endtask

    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] eo, output logic ez, output logic en,
                         output logic ec, output int elat);
        int          n, fb;
        logic [15:0] t;
        logic [7:0]  fs;
        n    = (b > 8'd8) ? 8 : int'(b);
        elat = 1;
        ec   = 1'b0;
        case (op)
            4'd0: begin t = {8'h0, a} + {8'h0, b}; m_out = t[7:0]; ec = t[8]; end
            4'd1: begin m_out = a - b; ec = (a >= b); end
            4'd2: m_out = a ^ b;
            4'd3: m_out = a & b;
            4'd4: begin
                t = {8'h0, a} << n; m_out = t[7:0];
                ec = (n > 0) ? t[8] : 1'b0; elat = n + 1;
            end
            4'd5: begin
                m_out = a >> n;
                ec = (n > 0) ? a[n-1] : 1'b0; elat = n + 1;
            end
            4'd6: begin ec = (a >= b); end
            4'd7: m_out = b;
            4'd8: m_out = {($countones(b[6:0]) % 2) == 1, b[6:0]};
            4'd9: begin
                m_s = (a == 0) ? 8'h01 : a;
                m_t = (b == 0) ? 8'hB8 : b;
                m_out = a;
            end
            4'd10: begin
                if (m_s == 0) begin
                    m_s = 8'h01;
                end else begin
                    ec  = (m_s >= 8'd128);
                    fb  = $countones(m_s & m_t) % 2;
                    m_s = 8'((int'(m_s) * 2 + fb) % 256);
                end
                m_out = m_s;
            end
            default: m_out = 8'h00;
        endcase
        fs = (op == 4'd6) ? 8'(a - b) : m_out;
        eo = m_out;
        ez = (fs == 0);
        en = (fs >= 8'd128);
    endtask

    // Launch one op and check result, flags, latency, busy time and pulse width.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eo, input logic ez, input logic en,
                          input logic ec, input int elat);
        int lat, busy;
        bit got;
        @(negedge Clk);
        Start = 1'b1; OP = op; InputA = a; InputB = b;
        lat = 0; busy = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            lat++;
            if (Done) got = 1'b1;
            else if (Busy) busy++;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", lat, elat);
        chk("busy_cycles", busy, elat - 1);
        chk("out", 32'(Out), 32'(eo));
        chk("zero", 32'(Zero), 32'(ez));
        chk("neg", 32'(Negative), 32'(en));
        chk("carry", 32'(Carry), 32'(ec));
        @(posedge Clk); #1;
        chk("done_one_cycle", 32'(Done), 32'd0);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, out;
        logic       z, n, c;
        int         lat;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] o, input logic z, input logic n,
                                input logic c, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.out = o; v.z = z; v.n = n; v.c = c; v.lat = lat;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [7:0] eo, a, b;
        logic       ez, en, ec;
        logic [3:0] op;
        int         elat, dones;
        logic [7:0] got_out;
        logic       got_c;

        //            op     A      B      Out    Z  N  C  lat
        tbl.push_back(mk(4'd0, 8'hF0, 8'h20, 8'h10, 0, 0, 1, 1));
        tbl.push_back(mk(4'd6, 8'h05, 8'h05, 8'h10, 1, 0, 1, 1));
        tbl.push_back(mk(4'd4, 8'h81, 8'h03, 8'h08, 0, 0, 0, 4));
        tbl.push_back(mk(4'd4, 8'h81, 8'h09, 8'h00, 1, 0, 1, 9));
        tbl.push_back(mk(4'd9, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(4'd10, 8'h00, 8'h00, 8'h02, 0, 0, 0, 1));
        tbl.push_back(mk(4'd10, 8'h00, 8'h00, 8'h04, 0, 0, 0, 1));
        tbl.push_back(mk(4'd10, 8'h00, 8'h00, 8'h08, 0, 0, 0, 1));
        tbl.push_back(mk(4'd9, 8'h80, 8'hB8, 8'h80, 0, 1, 0, 1));
        tbl.push_back(mk(4'd10, 8'h00, 8'h00, 8'h01, 0, 0, 1, 1));
        tbl.push_back(mk(4'd9, 8'h80, 8'h01, 8'h80, 0, 1, 0, 1));
        tbl.push_back(mk(4'd10, 8'h00, 8'h00, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(4'd10, 8'h00, 8'h00, 8'h01, 0, 0, 0, 1));
        tbl.push_back(mk(4'd1, 8'h03, 8'h05, 8'hFE, 0, 1, 0, 1));
        tbl.push_back(mk(4'd1, 8'h05, 8'h05, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(4'd2, 8'hA5, 8'h0F, 8'hAA, 0, 1, 0, 1));
        tbl.push_back(mk(4'd3, 8'hA5, 8'h0F, 8'h05, 0, 0, 0, 1));
        tbl.push_back(mk(4'd7, 8'h12, 8'h00, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(4'd8, 8'h00, 8'h07, 8'h87, 0, 1, 0, 1));
        tbl.push_back(mk(4'd8, 8'h00, 8'h03, 8'h03, 0, 0, 0, 1));
        tbl.push_back(mk(4'd12, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(4'd5, 8'h81, 8'h00, 8'h81, 0, 1, 0, 1));
        tbl.push_back(mk(4'd5, 8'h81, 8'h01, 8'h40, 0, 0, 1, 2));
        tbl.push_back(mk(4'd5, 8'h81, 8'h08, 8'h00, 1, 0, 1, 9));
        tbl.push_back(mk(4'd6, 8'h01, 8'h02, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(4'd0, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 1));

        // Reset state
        tag = "reset";
        Reset = 1'b1; Start = 1'b0; OP = 4'd0; InputA = 8'h00; InputB = 8'h00;
        model_reset();
        repeat (2) @(negedge Clk);
        chk("out", 32'(Out), 32'd0);
        chk("zero", 32'(Zero), 32'd0);
        chk("neg", 32'(Negative), 32'd0);
        chk("carry", 32'(Carry), 32'd0);
        chk("busy", 32'(Busy), 32'd0);
        chk("done", 32'(Done), 32'd0);
        Reset = 1'b0;

        // Directed vector table
        foreach (tbl[i]) begin
            tag = $sformatf("vec%0d_op%0d", i, tbl[i].op);
            model(tbl[i].op, tbl[i].a, tbl[i].b, eo, ez, en, ec, elat);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].out, tbl[i].z, tbl[i].n,
                   tbl[i].c, tbl[i].lat);
        end

        // Start held high throughout a shift: exactly one Done, original operands
        tag = "start_in_shift";
        @(negedge Clk);
        Start = 1'b1; OP = 4'd4; InputA = 8'h81; InputB = 8'h03;
        @(posedge Clk); #1;
        OP = 4'd0; InputA = 8'h01; InputB = 8'h01;
        dones = 0; got_out = 8'h00; got_c = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge Clk); #1;
            if (k == 3) Start = 1'b0;
            if (Done) begin dones++; got_out = Out; got_c = Carry; end
        end
        chk("done_count", dones, 1);
        chk("out", 32'(got_out), 32'h08);
        chk("carry", 32'(got_c), 32'd0);
        m_out = 8'h08;

        // Reset two cycles into an LSR by 6: abort, no Done, LFSR reseeded
        tag = "reset_mid_shift";
        @(negedge Clk);
        Start = 1'b1; OP = 4'd5; InputA = 8'hFF; InputB = 8'h06;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        chk("busy_before", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        chk("busy", 32'(Busy), 32'd0);
        chk("done", 32'(Done), 32'd0);
        chk("out", 32'(Out), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk); #1;
            if (Done || Busy) dones++;
        end
        chk("no_done_after_abort", dones, 0);
        tag = "reset_mid_shift_lstep";
        model(4'd10, 8'h00, 8'h00, eo, ez, en, ec, elat);
        run_op(4'd10, 8'h00, 8'h00, eo, ez, en, ec, elat);

        // Randomized ops against the model
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (op == 4'd4 || op == 4'd5) b = 8'($urandom_range(0, 11));
            if ($urandom_range(0, 5) == 0) a = 8'h00;
            if ($urandom_range(0, 5) == 0) b = 8'h00;
            tag = $sformatf("rnd%0d_op%0d_a%0h_b%0h", i, op, a, b);
            model(op, a, b, eo, ez, en, ec, elat);
            run_op(op, a, b, eo, ez, en, ec, elat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
